// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the two-read, one-write register file.
package reg_file_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 8;

  localparam int WR_COUNT_W = 8;

  typedef logic [WR_COUNT_W-1:0] wr_count_t;

  localparam wr_count_t WR_COUNT_MAX = 8'd255;

  // The write counter stops at its maximum so software can tell it has overflowed.
  function automatic wr_count_t wr_count_next(input wr_count_t count);
    wr_count_t next_count;
    next_count = count;
    if (count != WR_COUNT_MAX) begin
      next_count = count + 1'b1;
    end
    return next_count;
  endfunction

endpackage

// File: rtl/reg_read_mux.sv
// Combinational DEPTH:1 read selector over a flattened register array.
// An address at or beyond DEPTH selects nothing and yields zero, so DEPTH
// does not need to be a power of two.
module reg_read_mux
  import reg_file_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic [DEPTH*WIDTH-1:0] i_regs,
  input  logic [AW-1:0]          i_addr,
  output logic [WIDTH-1:0]       o_data
);

  // Pick the register whose index matches the address; no match leaves zero.
  always_comb begin
    o_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (i_addr == AW'(i)) begin
        o_data = i_regs[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised register file with one synchronous write port and two
// registered read ports. Reads see a same-edge write through a bypass,
// register 0 can be hardwired to zero, and out-of-range addresses are
// ignored on write and read back as zero.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = 1,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [WIDTH-1:0]      i_wr_data,
  input  logic [AW-1:0]         i_rd_addr_a,
  input  logic [AW-1:0]         i_rd_addr_b,
  output logic [WIDTH-1:0]      o_rd_data_a,
  output logic [WIDTH-1:0]      o_rd_data_b,
  output logic [WR_COUNT_W-1:0] o_wr_count
);

  localparam logic [AW:0] DEPTH_LIMIT = (AW+1)'(DEPTH);
  localparam bit HAS_ZERO_REG = (ZERO_REG != 0);

  logic [WIDTH-1:0]       r_mem [DEPTH];
  logic [DEPTH*WIDTH-1:0] w_flat;
  logic [WIDTH-1:0]       r_rd_data_a;
  logic [WIDTH-1:0]       r_rd_data_b;
  wr_count_t              r_wr_count;

  logic                   w_wr_in_range;
  logic                   w_wr_to_zero;
  logic                   w_wr_accept;
  logic [WIDTH-1:0]       w_mux_a;
  logic [WIDTH-1:0]       w_mux_b;
  logic [WIDTH-1:0]       w_next_a;
  logic [WIDTH-1:0]       w_next_b;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flatten
    assign w_flat[g*WIDTH +: WIDTH] = r_mem[g];
  end

  assign w_wr_in_range = ({1'b0, i_wr_addr} < DEPTH_LIMIT);
  assign w_wr_to_zero  = HAS_ZERO_REG && (i_wr_addr == '0);
  assign w_wr_accept   = i_wr_en && w_wr_in_range && !w_wr_to_zero;

  reg_read_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mux_a (
    .i_regs (w_flat),
    .i_addr (i_rd_addr_a),
    .o_data (w_mux_a)
  );

  reg_read_mux #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mux_b (
    .i_regs (w_flat),
    .i_addr (i_rd_addr_b),
    .o_data (w_mux_b)
  );

  // Storage: clear everything on reset, otherwise commit an accepted write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_accept && (i_wr_addr == AW'(i))) begin
          r_mem[i] <= i_wr_data;
        end
      end
    end
  end

  // Next read values: zero register wins, then bypass of this edge's write, then storage.
  always_comb begin
    w_next_a = w_mux_a;
    if (HAS_ZERO_REG && (i_rd_addr_a == '0)) begin
      w_next_a = '0;
    end else if (w_wr_accept && (i_wr_addr == i_rd_addr_a)) begin
      w_next_a = i_wr_data;
    end

    w_next_b = w_mux_b;
    if (HAS_ZERO_REG && (i_rd_addr_b == '0)) begin
      w_next_b = '0;
    end else if (w_wr_accept && (i_wr_addr == i_rd_addr_b)) begin
      w_next_b = i_wr_data;
    end
  end

  // Output registers for both read ports, refreshed every cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_data_a <= '0;
      r_rd_data_b <= '0;
    end else begin
      r_rd_data_a <= w_next_a;
      r_rd_data_b <= w_next_b;
    end
  end

  // Count accepted writes, saturating at the counter maximum.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_count <= '0;
    end else if (w_wr_accept) begin
      r_wr_count <= wr_count_next(r_wr_count);
    end
  end

  assign o_rd_data_a = r_rd_data_a;
  assign o_rd_data_b = r_rd_data_b;
  assign o_wr_count  = r_wr_count;

endmodule

// File: doc/reg_file_2r1w.md
# reg_file_2r1w

Parametrised register file: DEPTH registers of WIDTH bits, one synchronous write port, two independent registered read ports. It replaces the fixed four-register, single-read-port combinational selector in the datapath. Each read port is built on an N:1 read multiplexer. The file adds same-cycle write-to-read bypass, an optional hardwired zero register, and out-of-range address protection.

## Interface
Parameters:
- WIDTH, 32: bits per register.
- DEPTH, 8: number of registers; any value ≥ 2, not required to be a power of two.
- ZERO_REG, 1: when 1, register 0 always reads 0 and ignores writes.
- AW, $clog2(DEPTH): address width, derived; not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clk.
- wr_en  in  1  write strobe.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- rd_addr_a  in  AW  port A read address.
- rd_addr_b  in  AW  port B read address.
- rd_data_a  out  WIDTH  port A data, registered.
- rd_data_b  out  WIDTH  port B data, registered.
- wr_count  out  8  number of accepted writes since reset; saturates at 255.

## Operation
- Reset:
  - All DEPTH registers clear to 0.
  - rd_data_a, rd_data_b and wr_count clear to 0.
  - reset has priority over every other input in the same cycle. A write presented with reset high is discarded.
- Write acceptance:
  - A write is accepted on an edge when wr_en=1, wr_addr < DEPTH, and not (ZERO_REG=1 and wr_addr=0).
  - An accepted write sets mem[wr_addr] <= wr_data and increments wr_count by 1.
  - Any other write does nothing and leaves wr_count unchanged.
- Read, per port p in {a, b}, evaluated each edge:
  - If rd_addr_p ≥ DEPTH: rd_data_p <= 0.
  - Else if ZERO_REG=1 and rd_addr_p=0: rd_data_p <= 0.
  - Else if the write is accepted and wr_addr = rd_addr_p (bypass): rd_data_p <= wr_data, i.e. the new value, never the stale one.
  - Else: rd_data_p <= mem[rd_addr_p].
- Both ports may read the same address, including the address being written; each port independently returns the same bypassed value.
- Reads have no enable. Outputs update every cycle.
- wr_count saturates: at 255, further accepted writes leave it at 255.

## Timing
- Read latency is 1 cycle. An address presented before edge k appears on rd_data_p after edge k and holds until edge k+1.
- Write-to-read latency:
  - Same address presented on the same edge: 1 cycle, via bypass.
  - Read issued on a later edge: 1 cycle, from storage.
- Reset mid-operation: the edge with reset=1 forces all state to 0. The first edge after reset deasserts reads storage, which is all zeros, unless a write is bypassed on that edge.
- No combinational path from any input to any output.

## Structure
- Shared package reg_file_pkg holds:
  - default WIDTH and DEPTH constants;
  - the wr_count width (8) and its saturation value (255).
- Sub-module reg_read_mux: combinational DEPTH:1 multiplexer, parametrised on WIDTH and DEPTH.
  - Inputs: flattened register array and address.
  - Output: 0 for an out-of-range address.
  - Instantiated once per read port. Bypass, zero-register logic and the output registers stay in reg_file_2r1w.
- Storage, write decode, wr_count, and the two output registers live in the top module.

## Test plan
Defaults throughout (WIDTH=32, DEPTH=8, ZERO_REG=1) except scenario 5.
1. Reset then idle:
   - reset=1 for 2 cycles, then sweep rd_addr_a over 0..7 with no writes.
   - Required: every rd_data_a = 0; wr_count = 0.
2. Write then read:
   - Write 0xDEADBEEF to addr 3, then 0x12345678 to addr 5.
   - Then rd_addr_a=3, rd_addr_b=5.
   - Required: next cycle rd_data_a=0xDEADBEEF, rd_data_b=0x12345678; wr_count=2.
3. Bypass:
   - Same edge: wr_en=1, wr_addr=6, wr_data=0xA5A5A5A5, rd_addr_a=6, rd_addr_b=6.
   - Required: both ports show 0xA5A5A5A5 one cycle later.
4. Zero register:
   - Write 0xFFFFFFFF to addr 0 while rd_addr_a=0.
   - Required: rd_data_a=0 on that and every later read; wr_count unchanged.
5. Out-of-range addresses, DEPTH=6:
   - Write 0x1 to addr 7, then read addr 7 and addr 6.
   - Required: reads return 0; wr_count unchanged; mem[0..5] unchanged.
6. Reset priority and saturation:
   - 300 accepted writes. Required: wr_count = 255.
   - Then reset=1 together with a write of 0x77 to addr 2. Required: next cycle wr_count=0, and a subsequent read of addr 2 returns 0.
